// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter that shares one 8-bit FIFO write
// port among N_REQ valid/ready producers. A granted producer keeps the port
// for up to MAX_BURST beats, or until it drops valid. The grant then rotates
// to the next valid producer in the same cycle.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 4,
  parameter int IDX_W     = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 fifo_write,
  output logic [7:0]           fifo_wdata,
  input  logic                 fifo_full,
  output logic [N_REQ-1:0]     grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant_idx, w_grant_idx_nxt;
  logic [IDX_W-1:0]   r_last_idx, w_last_idx_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [CNT_W-1:0]   w_beat_inc;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic               w_any_valid;
  logic               w_owner_valid;
  logic               w_transfer;
  logic               w_release;

  // First valid requester after base, wrapping around; base itself is last.
  function automatic logic [IDX_W-1:0] f_pick(input logic [N_REQ-1:0] vld,
                                               input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] res;
    logic             found;
    int               idx;
    res   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(base) + k) % N_REQ;
      if (!found && vld[idx]) begin
        res   = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_any_valid   = |req_valid;
  assign w_owner_valid = req_valid[r_grant_idx];
  assign w_beat_inc    = r_beat_cnt + CNT_W'(1);

  // Handshake decode: only the owner sees ready, and only while the FIFO has room.
  always_comb begin
    req_ready  = '0;
    w_transfer = 1'b0;
    fifo_wdata = 8'h00;
    if (r_state == S_GRANT) begin
      for (int i = 0; i < N_REQ; i++)
        req_ready[i] = (i == int'(r_grant_idx)) && !fifo_full;
      w_transfer = w_owner_valid && !fifo_full;
      if (w_transfer)
        fifo_wdata = req_data[int'(r_grant_idx)*8 +: 8];
    end
  end

  assign fifo_write = w_transfer;
  assign busy       = (r_state == S_GRANT);
  assign grant      = r_grant;
  assign grant_idx  = r_grant_idx;

  // Next-state logic: arbitration from IDLE, beat counting and burst release.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_idx_nxt = r_grant_idx;
    w_last_idx_nxt  = r_last_idx;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_release       = 1'b0;
    w_grant_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt     = S_GRANT;
          w_grant_idx_nxt = f_pick(req_valid, r_last_idx);
          w_beat_cnt_nxt  = '0;
        end
      end
      S_GRANT: begin
        if (w_transfer) begin
          w_beat_cnt_nxt = w_beat_inc;
          if (w_beat_inc == CNT_W'(MAX_BURST))
            w_release = 1'b1;
        end
        if (!w_owner_valid)
          w_release = 1'b1;
        if (w_release) begin
          w_last_idx_nxt = r_grant_idx;
          w_beat_cnt_nxt = '0;
          if (w_any_valid) begin
            w_grant_idx_nxt = f_pick(req_valid, r_grant_idx);
          end else begin
            w_state_nxt     = S_IDLE;
            w_grant_idx_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_grant_idx_nxt = '0;
        w_beat_cnt_nxt  = '0;
      end
    endcase
    for (int i = 0; i < N_REQ; i++)
      w_grant_nxt[i] = (w_state_nxt == S_GRANT) && (i == int'(w_grant_idx_nxt));
  end

  // State registers; reset makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_grant_idx <= '0;
      r_last_idx  <= IDX_W'(N_REQ - 1);
      r_beat_cnt  <= '0;
      r_grant     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single write port of one 8-bit `fifo` instance between N_REQ producers. Each producer uses a valid/ready handshake. One producer holds the grant for a burst of up to MAX_BURST beats, so beats from different producers are not interleaved within a burst. The arbiter sits directly in front of the FIFO: it drives `write`/`wdata` and consumes `full`.

Parameters:
- N_REQ, 2, number of requesters (>=2).
- MAX_BURST, 4, maximum beats per grant before forced rotation (>=1).
- IDX_W, $clog2(N_REQ), width of the grant index.
- CNT_W, $clog2(MAX_BURST+1), width of the beat counter.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  N_REQ  requester i has a byte on req_data[8i+7:8i].
- req_data  in  8*N_REQ  packed requester bytes.
- req_ready  out  N_REQ  byte of requester i is accepted this cycle when req_valid[i] & req_ready[i].
- fifo_write  out  1  to FIFO `write`.
- fifo_wdata  out  8  to FIFO `wdata`.
- fifo_full  in  1  from FIFO `full`.
- grant  out  N_REQ  one-hot registered grant; all zero when idle.
- grant_idx  out  IDX_W  index of the current grant; 0 when idle.
- busy  out  1  high in GRANT state.

Behaviour:
- State machine: IDLE, GRANT. Registers: state, grant_idx, beat_cnt (CNT_W), last_idx (IDX_W).
- Reset (rst=0, takes effect immediately, asynchronous):
  - state=IDLE, grant=0, grant_idx=0, beat_cnt=0, last_idx=N_REQ-1, so requester 0 has first priority.
  - Outputs while in reset: req_ready=0, fifo_write=0, fifo_wdata=0, busy=0.
- Round-robin pick, function of req_valid and a base index b:
  - Result is the first i with req_valid[i]=1, scanning b+1, b+2, ... modulo N_REQ and ending at b itself.
  - Requester b therefore has the lowest priority.
- IDLE:
  - If any req_valid bit is set: go to GRANT with grant_idx = pick(req_valid, last_idx) and beat_cnt=0.
  - Otherwise stay in IDLE.
  - Arbitration latency is 1 cycle: valid seen in cycle t gives the grant in cycle t+1.
- GRANT, with g = grant_idx:
  - req_ready[i] = (i==g) & ~fifo_full. req_ready never depends on req_valid.
  - transfer = req_valid[g] & ~fifo_full.
  - fifo_write = transfer; fifo_wdata = req_data[g] when transfer, else 0.
  - If fifo_full=1 and req_valid[g]=1: hold. No write, beat_cnt unchanged, grant kept. Other requesters wait; there is no timeout.
  - If transfer=1: beat_cnt increments. If beat_cnt+1 == MAX_BURST, release.
  - If req_valid[g]=0: release with no transfer. Dropping valid ends the burst.
- Release, all in the same cycle:
  - last_idx = g.
  - If any req_valid bit is set: stay in GRANT with grant_idx = pick(req_valid, g) and beat_cnt=0. Handoff has zero bubble cycles.
  - If requester g is the only one valid after its final beat, it is re-granted.
  - If no req_valid bit is set: go to IDLE.
- FIFO contract:
  - Relies on `full` being a registered FIFO state, so there is no combinational loop.
  - The arbiter never asserts fifo_write while fifo_full=1.
  - Reads on the FIFO side are independent of the arbiter.
- Data ordering: beats from one requester reach the FIFO in their acceptance order. A burst of up to MAX_BURST beats is contiguous in the FIFO, apart from stall cycles.
- Invariants:
  - grant is one-hot or zero.
  - fifo_write implies popcount(req_valid & req_ready) == 1.
  - beat_cnt < MAX_BURST in GRANT.

Test Plan:
- Reset check: hold rst=0 with req_valid=2'b11 -> grant=0, fifo_write=0, req_ready=0. Release reset in cycle 0 -> grant=2'b01 at cycle 1.
- Single requester, N_REQ=2, MAX_BURST=4, FIFO DEPTH=4: req 1 sends 0x11, 0x22, 0x33, then drops valid. Required response:
  - grant=2'b10 one cycle after valid.
  - fifo_write high for 3 consecutive cycles.
  - FIFO reads 0x11, 0x22, 0x33.
  - Next cycle: IDLE with busy=0.
- Both requesters continuously valid, MAX_BURST=4, FIFO drained every cycle: grant sequence is 0 for 4 beats, then 1 for 4 beats, then 0, with no cycle where fifo_write=0 between bursts.
- Backpressure: after 2 beats of req 0, force fifo_full=1 for 3 cycles. Required response:
  - req_ready=0 and fifo_write=0 for those 3 cycles.
  - grant stays on req 0.
  - After full clears, exactly 2 more beats, then grant moves to req 1.
- Reset mid-burst: assert rst=0 during beat 2 of a req 1 burst. Required response:
  - grant=0 and fifo_write=0 immediately, without waiting for a clock edge.
  - After release, with both requesters valid, req 0 is granted first.
- Round-robin skip, N_REQ=3: req 0 and req 2 valid, req 1 idle, MAX_BURST=1 -> grant alternates 0, 2, 0, 2. Req 1 is never granted.
